// File: rtl/dds_cfg_ctrl_if.sv
// Configuration handshake between the DDS config controller (master) and the DDS core (slave).
interface dds_cfg_ctrl_if #(
  parameter int FW_W = 32,
  parameter int PW_W = 12
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_wave;
  logic [FW_W-1:0] cfg_freq;
  logic [PW_W-1:0] cfg_phase;
  logic [2:0]      cfg_amp;

  modport master (
    output cfg_valid, cfg_wave, cfg_freq, cfg_phase, cfg_amp,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_wave, cfg_freq, cfg_phase, cfg_amp,
    output cfg_ready
  );
endinterface

// File: rtl/dds_cfg_ctrl.sv
// Key-driven DDS configuration editor: shadow registers edited by key pulses,
// delivered to the DDS core over valid/ready with coalescing of pending edits.
//   state | meaning
//   IDLE  | no payload offered; loads shadow into payload when dirty
//   PEND  | payload offered and held until a transfer edge
module dds_cfg_ctrl #(
  parameter int              FW_W       = 32,
  parameter int              PW_W       = 12,
  parameter logic [FW_W-1:0] FREQ_INIT  = FW_W'(85_899),
  parameter logic [FW_W-1:0] FREQ_STEP  = FW_W'(85_899),
  parameter logic [FW_W-1:0] FREQ_MIN   = FW_W'(85_899),
  parameter logic [FW_W-1:0] FREQ_MAX   = FW_W'(429_496_730),
  parameter logic [PW_W-1:0] PHASE_STEP = PW_W'(256)
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic [3:0]     key_flag,
  output logic [1:0]     field_sel,
  dds_cfg_ctrl_if.master cfg
);

  typedef enum logic {IDLE, PEND} state_t;

  localparam logic [1:0] FLD_FREQ  = 2'd0;
  localparam logic [1:0] FLD_PHASE = 2'd1;
  localparam logic [1:0] FLD_AMP   = 2'd2;

  state_t          state, state_nxt;
  logic [1:0]      sh_wave, wave_nxt;
  logic [FW_W-1:0] sh_freq, freq_nxt;
  logic [PW_W-1:0] sh_phase, phase_nxt;
  logic [2:0]      sh_amp, amp_nxt;
  logic [1:0]      field_nxt;
  logic            dirty, dirty_nxt, key_dirty;
  logic            load, load_post, valid_nxt;
  logic [FW_W:0]   freq_up, freq_dn_lim;

  // One extra bit keeps the saturation compares free of wraparound.
  assign freq_up     = {1'b0, sh_freq} + {1'b0, FREQ_STEP};
  assign freq_dn_lim = {1'b0, FREQ_MIN} + {1'b0, FREQ_STEP};

  always_comb begin
    wave_nxt  = sh_wave;
    freq_nxt  = sh_freq;
    phase_nxt = sh_phase;
    amp_nxt   = sh_amp;
    field_nxt = field_sel;
    key_dirty = 1'b0;
    if (key_flag[0]) begin
      wave_nxt  = sh_wave + 2'd1;
      key_dirty = 1'b1;
    end else if (key_flag[1]) begin
      field_nxt = (field_sel == FLD_AMP) ? FLD_FREQ : field_sel + 2'd1;
    end else if (key_flag[2]) begin
      key_dirty = 1'b1;
      case (field_sel)
        FLD_FREQ:  freq_nxt  = (freq_up > {1'b0, FREQ_MAX}) ? FREQ_MAX : freq_up[FW_W-1:0];
        FLD_PHASE: phase_nxt = sh_phase + PHASE_STEP;
        FLD_AMP:   amp_nxt   = (sh_amp == 3'd7) ? sh_amp : sh_amp + 3'd1;
        default:   ;
      endcase
    end else if (key_flag[3]) begin
      key_dirty = 1'b1;
      case (field_sel)
        FLD_FREQ:  freq_nxt  = ({1'b0, sh_freq} < freq_dn_lim) ? FREQ_MIN : sh_freq - FREQ_STEP;
        FLD_PHASE: phase_nxt = sh_phase - PHASE_STEP;
        FLD_AMP:   amp_nxt   = (sh_amp == 3'd0) ? sh_amp : sh_amp - 3'd1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_post = 1'b0;
    valid_nxt = cfg.cfg_valid;
    dirty_nxt = dirty | key_dirty;
    case (state)
      IDLE: begin
        if (dirty) begin
          load      = 1'b1;
          valid_nxt = 1'b1;
          dirty_nxt = key_dirty;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cfg.cfg_valid && cfg.cfg_ready) begin
          // An edit landing in the transfer cycle is folded into the reload.
          if (dirty || key_dirty) begin
            load      = 1'b1;
            load_post = 1'b1;
            dirty_nxt = 1'b0;
          end else begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      sh_wave       <= 2'd0;
      sh_freq       <= FREQ_INIT;
      sh_phase      <= '0;
      sh_amp        <= 3'd7;
      field_sel     <= FLD_FREQ;
      dirty         <= 1'b1;
      cfg.cfg_valid <= 1'b0;
      cfg.cfg_wave  <= 2'd0;
      cfg.cfg_freq  <= FREQ_INIT;
      cfg.cfg_phase <= '0;
      cfg.cfg_amp   <= 3'd7;
    end else begin
      state         <= state_nxt;
      sh_wave       <= wave_nxt;
      sh_freq       <= freq_nxt;
      sh_phase      <= phase_nxt;
      sh_amp        <= amp_nxt;
      field_sel     <= field_nxt;
      dirty         <= dirty_nxt;
      cfg.cfg_valid <= valid_nxt;
      if (load) begin
        cfg.cfg_wave  <= load_post ? wave_nxt  : sh_wave;
        cfg.cfg_freq  <= load_post ? freq_nxt  : sh_freq;
        cfg.cfg_phase <= load_post ? phase_nxt : sh_phase;
        cfg.cfg_amp   <= load_post ? amp_nxt   : sh_amp;
      end
    end
  end

endmodule

// File: tb/tb_dds_cfg_ctrl.sv
// Self-checking bench for dds_cfg_ctrl: directed scenarios plus a randomized run
// compared against an arithmetic model of the editable configuration.
module tb_dds_cfg_ctrl;

  localparam longint F_STEP = 85_899;
  localparam longint F_MIN  = 85_899;
  localparam longint F_MAX  = 429_496_730;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [3:0] key_flag = 4'b0;
  logic [1:0] field_sel;
  logic [48:0] dut_vec;

  int errors = 0;
  int checks = 0;

  int     m_wave, m_field, m_phase, m_amp;
  longint m_freq;

  dds_cfg_ctrl_if #(.FW_W(32), .PW_W(12)) cfg_if ();

  dds_cfg_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_flag  (key_flag),
    .field_sel (field_sel),
    .cfg       (cfg_if.master)
  );

  assign dut_vec = {cfg_if.cfg_wave, cfg_if.cfg_freq, cfg_if.cfg_phase, cfg_if.cfg_amp};

  always #5 sys_clk = ~sys_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic logic [48:0] model_vec();
    logic [1:0]  w;
    logic [31:0] f;
    logic [11:0] p;
    logic [2:0]  a;
    w = 2'(m_wave);
    f = 32'(m_freq);
    p = 12'(m_phase);
    a = 3'(m_amp);
    return {w, f, p, a};
  endfunction

  task automatic model_reset();
    m_wave = 0; m_freq = 85_899; m_phase = 0; m_amp = 7; m_field = 0;
  endtask

  task automatic model_key(input logic [3:0] k);
    int dir;
    if (k[0]) m_wave = (m_wave + 1) % 4;
    else if (k[1]) m_field = (m_field + 1) % 3;
    else if (k[2] || k[3]) begin
      dir = k[2] ? 1 : -1;
      case (m_field)
        0: begin
          m_freq = m_freq + dir * F_STEP;
          if (m_freq > F_MAX) m_freq = F_MAX;
          if (m_freq < F_MIN) m_freq = F_MIN;
        end
        1: m_phase = (m_phase + 4096 + dir * 256) % 4096;
        default: begin
          m_amp = m_amp + dir;
          if (m_amp > 7) m_amp = 7;
          if (m_amp < 0) m_amp = 0;
        end
      endcase
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_flag = k;
    model_key(k);
    step();
    key_flag = 4'b0;
  endtask

  // Ready held high with no keys until valid has stayed low for three cycles.
  task automatic drain();
    int quiet = 0;
    int n = 0;
    cfg_if.cfg_ready = 1'b1;
    while (quiet < 3 && n < 40) begin
      step();
      quiet = cfg_if.cfg_valid ? 0 : quiet + 1;
      n++;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("FAIL drain_timeout: valid still active after %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    int nv = 0;
    logic [48:0] got = '0;
    sys_rst = 1'b1; cfg_if.cfg_ready = 1'b1; key_flag = 4'b0;
    repeat (3) step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b0 || field_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b field=%0d want valid=0 field=0", cfg_if.cfg_valid, field_sel);
    end
    model_reset();
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cfg_if.cfg_valid === 1'b1) begin nv++; got = dut_vec; end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL reset_offer_count: valid cycles=%0d want 1", nv);
    end
    checks++;
    if (got !== model_vec()) begin
      errors++;
      $display("FAIL reset_payload: got %h want %h", got, model_vec());
    end
  endtask

  task automatic test_freq();
    cfg_if.cfg_ready = 1'b1;
    key_flag = 4'b0100;
    for (int i = 0; i < 5000; i++) begin model_key(4'b0100); step(); end
    key_flag = 4'b0;
    drain();
    press(4'b0100);
    checks++;
    if (cfg_if.cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL freq_latency_early: valid=%b one cycle after pulse want 0", cfg_if.cfg_valid);
    end
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_freq !== 32'd429_496_730 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL freq_max: valid=%b freq=%0d want valid=1 freq=429496730", cfg_if.cfg_valid, cfg_if.cfg_freq);
    end
    step();
    press(4'b0100);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_freq !== 32'd429_496_730) begin
      errors++;
      $display("FAIL freq_resend: valid=%b freq=%0d want valid=1 freq=429496730", cfg_if.cfg_valid, cfg_if.cfg_freq);
    end
    key_flag = 4'b1000;
    for (int i = 0; i < 5005; i++) begin model_key(4'b1000); step(); end
    key_flag = 4'b0;
    drain();
    press(4'b1000);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_freq !== 32'd85_899 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL freq_min: valid=%b freq=%0d want valid=1 freq=85899", cfg_if.cfg_valid, cfg_if.cfg_freq);
    end
    drain();
  endtask

  task automatic test_field_phase();
    int nv = 0;
    press(4'b0010);
    if (cfg_if.cfg_valid === 1'b1) nv++;
    press(4'b0010);
    for (int i = 0; i < 4; i++) begin
      if (cfg_if.cfg_valid === 1'b1) nv++;
      step();
    end
    checks++;
    if (nv != 0 || field_sel !== 2'd2) begin
      errors++;
      $display("FAIL field_to_amp: field=%0d valid_cycles=%0d want field=2 valid_cycles=0", field_sel, nv);
    end
    press(4'b1000);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_amp !== 3'd6 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL amp_dec: valid=%b amp=%0d want valid=1 amp=6", cfg_if.cfg_valid, cfg_if.cfg_amp);
    end
    drain();
    press(4'b0010);
    checks++;
    if (field_sel !== 2'd0) begin
      errors++;
      $display("FAIL field_wrap: field=%0d want 0", field_sel);
    end
    press(4'b0010);
    checks++;
    if (field_sel !== 2'd1) begin
      errors++;
      $display("FAIL field_phase: field=%0d want 1", field_sel);
    end
    press(4'b1000);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_phase !== 12'd3840 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL phase_wrap: valid=%b phase=%0d want valid=1 phase=3840", cfg_if.cfg_valid, cfg_if.cfg_phase);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    press(4'b1101);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || cfg_if.cfg_wave !== 2'd1 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL simultaneous: valid=%b payload=%h want valid=1 payload=%h", cfg_if.cfg_valid, dut_vec, model_vec());
    end
    drain();
  endtask

  task automatic test_coalesce();
    logic [48:0] snap;
    logic stable = 1'b1;
    cfg_if.cfg_ready = 1'b0;
    press(4'b0010);
    press(4'b0010);
    checks++;
    if (field_sel !== 2'd0) begin
      errors++;
      $display("FAIL coalesce_field: field=%0d want 0", field_sel);
    end
    press(4'b0100);
    step();
    snap = model_vec();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || dut_vec !== snap) begin
      errors++;
      $display("FAIL coalesce_first: valid=%b payload=%h want valid=1 payload=%h", cfg_if.cfg_valid, dut_vec, snap);
    end
    repeat (5) step();
    press(4'b0001);
    for (int i = 0; i < 10; i++) begin
      if (cfg_if.cfg_valid !== 1'b1 || dut_vec !== snap) stable = 1'b0;
      step();
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL coalesce_hold: payload=%h valid=%b want payload=%h held", dut_vec, cfg_if.cfg_valid, snap);
    end
    cfg_if.cfg_ready = 1'b1;
    step();
    cfg_if.cfg_ready = 1'b0;
    checks++;
    if (cfg_if.cfg_valid !== 1'b1 || dut_vec !== model_vec()) begin
      errors++;
      $display("FAIL coalesce_reload: valid=%b payload=%h want valid=1 payload=%h", cfg_if.cfg_valid, dut_vec, model_vec());
    end
    cfg_if.cfg_ready = 1'b1;
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL coalesce_done: valid=%b want 0", cfg_if.cfg_valid);
    end
    drain();
  endtask

  task automatic test_reset_pend();
    int nv = 0;
    logic [48:0] got = '0;
    cfg_if.cfg_ready = 1'b0;
    press(4'b0001);
    press(4'b0100);
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b1) begin
      errors++;
      $display("FAIL pend_before_reset: valid=%b want 1", cfg_if.cfg_valid);
    end
    sys_rst = 1'b1;
    step();
    checks++;
    if (cfg_if.cfg_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_pend: valid=%b want 0", cfg_if.cfg_valid);
    end
    sys_rst = 1'b0;
    model_reset();
    cfg_if.cfg_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cfg_if.cfg_valid === 1'b1) begin nv++; got = dut_vec; end
    end
    checks++;
    if (nv != 1 || got !== model_vec() || field_sel !== 2'd0) begin
      errors++;
      $display("FAIL reset_pend_offer: count=%0d payload=%h field=%0d want 1 %h 0", nv, got, field_sel, model_vec());
    end
  endtask

  task automatic test_random();
    logic [3:0]  k;
    logic        hold = 1'b0;
    logic [48:0] prev = '0;
    logic [48:0] last = '0;
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (field_sel !== 2'(m_field)) begin
        errors++;
        $display("FAIL rand_field: cycle %0d field=%0d want %0d", i, field_sel, m_field);
      end
      if (hold) begin
        checks++;
        if (cfg_if.cfg_valid !== 1'b1 || dut_vec !== prev) begin
          errors++;
          $display("FAIL rand_stable: cycle %0d valid=%b payload=%h want valid=1 payload=%h", i, cfg_if.cfg_valid, dut_vec, prev);
        end
      end
      k = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      key_flag = k;
      model_key(k);
      cfg_if.cfg_ready = 1'($urandom_range(0, 1));
      if (cfg_if.cfg_valid && cfg_if.cfg_ready) last = dut_vec;
      hold = cfg_if.cfg_valid && !cfg_if.cfg_ready;
      prev = dut_vec;
      step();
    end
    key_flag = 4'b0;
    cfg_if.cfg_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (cfg_if.cfg_valid) last = dut_vec;
      step();
    end
    checks++;
    if (cfg_if.cfg_valid !== 1'b0 || last !== model_vec()) begin
      errors++;
      $display("FAIL rand_final: valid=%b last=%h want valid=0 last=%h", cfg_if.cfg_valid, last, model_vec());
    end
  endtask

  initial begin
    cfg_if.cfg_ready = 1'b1;
    step();
    test_reset();
    test_freq();
    test_field_phase();
    test_simultaneous();
    test_coalesce();
    test_reset_pend();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
